door_arbiter: RTL and testbench
===============================

# door_arbiter

Arbitrates a single shared doorway between an entry requester and an exit requester for the room-occupancy controller. It grants the door to one direction at a time, with round-robin fairness on ties. It tracks occupancy against a fixed capacity and drives the door unlock and room light. It sits between the doorway sensors and the lock actuators, replacing direct free-running lock control with a request/grant handshake.

## Interface
- CAPACITY, 4: maximum occupants; entry is refused at this count.
- CNT_W, 3: width of the occupancy count; must hold CAPACITY.
- TIMEOUT, 8: cycles a grant is held without a pass before it is abandoned.
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- entry_req  in  1  level; a person wants to enter.
- exit_req  in  1  level; a person wants to leave.
- passed  in  1  one-cycle pulse from the doorway sensor; the granted person crossed.
- entry_grant  out  1  door granted to the entry direction.
- exit_grant  out  1  door granted to the exit direction.
- door_unlock  out  1  door actuator; high while either grant is high.
- light_on  out  1  high when count != 0.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- count  out  CNT_W  current occupancy.

## Operation
- States: IDLE, IN, OUT, CLEAR. Outputs are Moore-decoded from registered state and count.
- Eligibility is evaluated in IDLE only:
  - entry eligible = entry_req && !full
  - exit eligible = exit_req && !empty
- IDLE transitions:
  - Only entry eligible -> IN.
  - Only exit eligible -> OUT.
  - Both eligible -> direction opposite to last_dir; last_dir updates on every grant.
  - Neither eligible -> stay in IDLE.
- IN: entry_grant=1, door_unlock=1. On passed: count+1, go to CLEAR.
- OUT: exit_grant=1, door_unlock=1. On passed: count-1, go to CLEAR.
- CLEAR: all grants and door_unlock low for one cycle (door closes), then IDLE.
- A request dropped while granted does not revoke the grant; the grant ends only on passed or timeout.
- passed in IDLE or CLEAR is ignored. count never changes outside IN/OUT.
- Overflow and underflow are impossible by construction. The counter still saturates at 0 and CAPACITY as a guard.
- Reset values:
  - state IDLE, count 0, last_dir=exit (so the first tie goes to entry), timer 0.
  - entry_grant 0, exit_grant 0, door_unlock 0, light_on 0, full 0, empty 1.
- Reset mid-operation: all of the above take effect immediately and asynchronously; any pending pass is lost.

## Timing
- Request sampled high in IDLE at edge k -> grant high after edge k, i.e. one-cycle latency.
- passed high at edge m in IN/OUT -> count, full, empty and light_on update after edge m; state is CLEAR.
- IDLE after edge m+1. The earliest next grant is after edge m+2.
- Back-to-back passes cost 3 cycles minimum per person.
- Simultaneous passed and timeout expiry: passed wins and count updates.

## Configuration
- DOOR_ARB_TIMEOUT_EN defined:
  - A timer clears on entry to IN/OUT and increments each cycle there.
  - When the timer reaches TIMEOUT-1 with no passed, go to CLEAR with count unchanged.
  - last_dir still records the abandoned direction.
- DOOR_ARB_TIMEOUT_EN undefined: no timer logic; IN/OUT wait indefinitely for passed. The TIMEOUT parameter is unused.

## Structure
- Shared package door_pkg holds:
  - the state enum (IDLE=2'b00, IN=2'b01, OUT=2'b10, CLEAR=2'b11);
  - the direction constants DIR_ENTRY and DIR_EXIT.
- One sub-module, occupancy_counter: up/down saturating counter (CAPACITY, CNT_W) with inc/dec strobes and full/empty/count outputs.
- The FSM, arbitration and optional timer stay in door_arbiter.

## Test plan
- Entry pass:
  - Stimulus: reset, then entry_req=1.
  - Required: entry_grant=1 and door_unlock=1 one cycle later; passed pulse -> count=1, light_on=1, empty=0; CLEAR one cycle (grants 0); then IDLE.
- Full:
  - Stimulus: four entry passes with CAPACITY=4.
  - Required: full=1; a held entry_req gets no grant for 20 cycles; exit_req -> exit_grant; after pass, count=3 and full=0.
- Tie fairness:
  - Stimulus: count=2, entry_req and exit_req both held, passed pulsed on every grant.
  - Required: grants follow entry, exit, entry, exit, entry, exit; final count=2.
- Empty:
  - Stimulus: count=0, exit_req=1.
  - Required: exit_grant stays 0, light_on stays 0.
- Timeout:
  - Stimulus: macro on, TIMEOUT=8; entry granted, no passed.
  - Required: grant drops after 8 cycles and count stays 0. With the macro off, the grant is still high at 50 cycles.
- Reset mid-grant:
  - Stimulus: count=3, state OUT, reset pulsed.
  - Required: same cycle, exit_grant=0, door_unlock=0, count=0, empty=1; a passed pulse after reset does not change count.

Source files
------------

// File: rtl/door_pkg.sv
// Shared types for the doorway arbiter: FSM state encoding and direction codes.
package door_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IN    = 2'b01,
        OUT   = 2'b10,
        CLEAR = 2'b11
    } door_state_e;

    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

endpackage

// File: rtl/occupancy_counter.sv
// Up/down occupancy counter that saturates at 0 and CAPACITY, with registered
// full/empty/light flags decoded from the next count.
module occupancy_counter #(
    parameter int CAPACITY = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             light_on
);

    localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_V = {CNT_W{1'b0}};

    logic [CNT_W-1:0] count_d, count_q;
    logic             full_d, full_q;
    logic             empty_d, empty_q;
    logic             light_d, light_q;

    // Next count with saturation guards and flags derived from it.
    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != CAP_V)) begin
            count_d = count_q + ONE_V;
        end else if (dec && !inc && (count_q != ZERO_V)) begin
            count_d = count_q - ONE_V;
        end else begin
            count_d = count_q;
        end
        full_d  = (count_d == CAP_V);
        empty_d = (count_d == ZERO_V);
        light_d = (count_d != ZERO_V);
    end

    // Count and flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= ZERO_V;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            light_q <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            light_q <= light_d;
        end
    end

    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign light_on = light_q;

endmodule

// File: rtl/door_arbiter.sv
// Doorway arbiter: round-robin grant of one shared door to entry or exit.
// Optional grant abandonment timer enabled by defining DOOR_ARB_TIMEOUT_EN.
module door_arbiter
    import door_pkg::*;
#(
    parameter int CAPACITY = 4,
    parameter int CNT_W    = 3,
    parameter int TIMEOUT  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             passed,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic             door_unlock,
    output logic             light_on,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    door_state_e state_d, state_q;
    logic        last_dir_d, last_dir_q;
    logic        entry_grant_d, entry_grant_q;
    logic        exit_grant_d, exit_grant_q;
    logic        unlock_d, unlock_q;
    logic        entry_ok, exit_ok, granted, timeout_hit;

`ifdef DOOR_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    logic [TMR_W-1:0] timer_d, timer_q;
`endif

    // Next-state, arbitration and registered-output decode.
    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        entry_ok   = entry_req && !full;
        exit_ok    = exit_req && !empty;
        granted    = (state_q == IN) || (state_q == OUT);
`ifdef DOOR_ARB_TIMEOUT_EN
        timeout_hit = granted && (timer_q == TMR_LAST);
`else
        timeout_hit = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // On a tie the direction not served last time wins.
                if (entry_ok && (!exit_ok || (last_dir_q == DIR_EXIT))) begin
                    state_d    = IN;
                    last_dir_d = DIR_ENTRY;
                end else if (exit_ok) begin
                    state_d    = OUT;
                    last_dir_d = DIR_EXIT;
                end else begin
                    state_d = IDLE;
                end
            end
            IN, OUT: begin
                if (passed || timeout_hit) begin
                    state_d = CLEAR;
                end else begin
                    state_d = state_q;
                end
            end
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        entry_grant_d = (state_d == IN);
        exit_grant_d  = (state_d == OUT);
        unlock_d      = (state_d == IN) || (state_d == OUT);
`ifdef DOOR_ARB_TIMEOUT_EN
        if (granted && (state_d == state_q)) begin
            timer_d = timer_q + TMR_ONE;
        end else begin
            timer_d = {TMR_W{1'b0}};
        end
`endif
    end

    // FSM state, arbitration history, timer and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_dir_q    <= DIR_EXIT;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            unlock_q      <= 1'b0;
`ifdef DOOR_ARB_TIMEOUT_EN
            timer_q       <= {TMR_W{1'b0}};
`endif
        end else begin
            state_q       <= state_d;
            last_dir_q    <= last_dir_d;
            entry_grant_q <= entry_grant_d;
            exit_grant_q  <= exit_grant_d;
            unlock_q      <= unlock_d;
`ifdef DOOR_ARB_TIMEOUT_EN
            timer_q       <= timer_d;
`endif
        end
    end

    occupancy_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_counter (
        .clock    (clock),
        .reset    (reset),
        .inc      ((state_q == IN) && passed),
        .dec      ((state_q == OUT) && passed),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .light_on (light_on)
    );

    assign entry_grant = entry_grant_q;
    assign exit_grant  = exit_grant_q;
    assign door_unlock = unlock_q;

endmodule

// File: tb/tb_door_arbiter.sv
// Directed and randomized bench for door_arbiter against a behavioural doorway model.
module tb_door_arbiter;

    localparam int CAP = 4;
    localparam int CW  = 3;
    localparam int TMO = 8;
`ifdef DOOR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          entry_req = 1'b0;
    logic          exit_req = 1'b0;
    logic          passed = 1'b0;
    logic          entry_grant, exit_grant, door_unlock, light_on, full, empty;
    logic [CW-1:0] count;

    int n_total = 0;
    int n_pass  = 0;

    // Model: who holds the door (0 nobody, 1 entering, 2 leaving), whether the
    // door is closing, occupancy, who wins the next tie, and how long the
    // current holder has waited.
    int m_owner = 0;
    bit m_closing = 1'b0;
    int m_count = 0;
    bit m_entry_next = 1'b1;
    int m_age = 0;

    door_arbiter #(.CAPACITY(CAP), .CNT_W(CW), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
        .passed(passed), .entry_grant(entry_grant), .exit_grant(exit_grant),
        .door_unlock(door_unlock), .light_on(light_on), .full(full),
        .empty(empty), .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".entry_grant"}, int'(entry_grant), int'(m_owner == 1));
        chk({tag, ".exit_grant"},  int'(exit_grant),  int'(m_owner == 2));
        chk({tag, ".door_unlock"}, int'(door_unlock), int'(m_owner != 0));
        chk({tag, ".light_on"},    int'(light_on),    int'(m_count > 0));
        chk({tag, ".full"},        int'(full),        int'(m_count == CAP));
        chk({tag, ".empty"},       int'(empty),       int'(m_count == 0));
        chk({tag, ".count"},       int'(count),       m_count);
    endtask

    function automatic void model_reset();
        m_owner = 0; m_closing = 1'b0; m_count = 0; m_entry_next = 1'b1; m_age = 0;
    endfunction

    function automatic void model_step();
        bit want_in, want_out;
        int who;
        if (m_owner != 0) begin
            if (passed) begin
                if (m_owner == 1 && m_count < CAP) m_count++;
                else if (m_owner == 2 && m_count > 0) m_count--;
                m_owner = 0; m_closing = 1'b1;
            end else if (TO_EN && m_age == TMO - 1) begin
                m_owner = 0; m_closing = 1'b1;
            end else begin
                m_age++;
            end
        end else if (m_closing) begin
            m_closing = 1'b0;
        end else begin
            want_in  = entry_req && (m_count < CAP);
            want_out = exit_req && (m_count > 0);
            if (want_in && want_out) who = m_entry_next ? 1 : 2;
            else if (want_in) who = 1;
            else if (want_out) who = 2;
            else who = 0;
            if (who != 0) begin
                m_owner = who; m_age = 0; m_entry_next = (who == 2);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all("cyc");
    endtask

    // Called just after a falling edge; reset is pulsed well before the next rising edge.
    task automatic apply_reset();
        #1 reset = 1'b1;
        model_reset();
        #1 check_all("async_rst");
        #1 reset = 1'b0;
    endtask

    task automatic do_pass(input int dir);
        logic got;
        if (dir == 1) entry_req = 1'b1; else exit_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            got = (dir == 1) ? entry_grant : exit_grant;
        end
        chk("grant_wait", int'(got), 1);
        entry_req = 1'b0; exit_req = 1'b0;
        passed = 1'b1; tick();
        passed = 1'b0; tick();
    endtask

    initial begin
        int order[6];
        int seen;
        logic got;
        @(negedge clock);
        apply_reset();
        chk("rst.empty", int'(empty), 1);

        // Entry pass with one-cycle grant latency.
        entry_req = 1'b1; tick();
        chk("entry.grant", int'(entry_grant), 1);
        entry_req = 1'b0; passed = 1'b1; tick();
        passed = 1'b0;
        chk("entry.count", int'(count), 1);
        chk("entry.clear_unlock", int'(door_unlock), 0);
        tick();

        // Fill the room, then hold entry while full.
        for (int i = 0; i < 3; i++) do_pass(1);
        chk("full.flag", int'(full), 1);
        entry_req = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("full.no_grant", int'(entry_grant), 0);
        do_pass(2);
        chk("full.count3", int'(count), 3);
        chk("full.cleared", int'(full), 0);

        // Reset while the exit grant is held.
        exit_req = 1'b1; tick();
        chk("mid.exit_grant", int'(exit_grant), 1);
        apply_reset();
        chk("mid.count", int'(count), 0);
        exit_req = 1'b0; passed = 1'b1; tick();
        passed = 1'b0; tick();
        chk("mid.ignored_pass", int'(count), 0);

        // Bring count to 2 with an exit as the last grant, then tie.
        for (int i = 0; i < 3; i++) do_pass(1);
        do_pass(2);
        entry_req = 1'b1; exit_req = 1'b1;
        for (int g = 0; g < 6; g++) begin
            got = 1'b0;
            for (int i = 0; i < 6 && !got; i++) begin
                tick();
                got = entry_grant | exit_grant;
            end
            chk("tie.grant_wait", int'(got), 1);
            order[g] = entry_grant ? 1 : 2;
            passed = 1'b1; tick();
            passed = 1'b0;
        end
        entry_req = 1'b0; exit_req = 1'b0; tick();
        for (int g = 0; g < 6; g++) begin
            seen = (g % 2 == 0) ? 1 : 2;
            chk("tie.order", order[g], seen);
        end
        chk("tie.final_count", int'(count), 2);

        // Drain, then exit requests on an empty room.
        do_pass(2); do_pass(2);
        exit_req = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("empty.no_grant", int'(exit_grant), 0);
        chk("empty.light", int'(light_on), 0);
        exit_req = 1'b0; tick();

        // Grant with no pass: abandoned after TIMEOUT cycles only when enabled.
        entry_req = 1'b1; tick();
        entry_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("tmo.held7", int'(entry_grant), 1);
        tick();
        chk("tmo.after8", int'(entry_grant), TO_EN ? 0 : 1);
        for (int i = 0; i < 42; i++) tick();
        chk("tmo.after50", int'(entry_grant), TO_EN ? 0 : 1);
        chk("tmo.count", int'(count), 0);
        apply_reset();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            entry_req = 1'($urandom_range(0, 1));
            exit_req  = 1'($urandom_range(0, 1));
            passed    = ($urandom_range(0, 3) == 0);
            tick();
            if (i == 200) apply_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
